// File: rtl/serial_adder_seq_if.sv
// Bus between the serial adder sequencer, its requester and the external 1-bit full-adder cell.
// Optional add/subtract signals (sub, ovf) exist only when SERIAL_ADDSUB_EN is defined.
interface serial_adder_seq_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef SERIAL_ADDSUB_EN
    logic             sub;
    logic             ovf;
`endif
    logic             fa_a;
    logic             fa_b;
    logic             fa_c;
    logic             fa_s;
    logic             fa_co;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    // Requester plus full-adder cell side.
    modport master (
        output start, a, b, cin, fa_s, fa_co,
`ifdef SERIAL_ADDSUB_EN
        output sub, input ovf,
`endif
        input  fa_a, fa_b, fa_c, busy, done, sum, cout
    );

    // Sequencer side.
    modport slave (
        input  start, a, b, cin, fa_s, fa_co,
`ifdef SERIAL_ADDSUB_EN
        input  sub, output ovf,
`endif
        output fa_a, fa_b, fa_c, busy, done, sum, cout
    );
endinterface

// File: rtl/serial_adder_seq.sv
// Bit-serial add sequencer driving one external full-adder cell, LSB first, WIDTH cycles per add.
// Define SERIAL_ADDSUB_EN to add the sub input (a - b) and the signed-overflow output ovf.
module serial_adder_seq #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_adder_seq_if.slave    bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum_sh;
    logic [WIDTH-1:0] r_sum;
    logic [CNT_W-1:0] r_cnt;
    logic             r_carry;
    logic             r_cout;
    logic             r_busy;
    logic             r_done;
    logic             w_accept;
    logic             w_last;
    logic [WIDTH-1:0] w_b_in;
    logic             w_c_in;
`ifdef SERIAL_ADDSUB_EN
    logic             r_ovf;
`endif

    // Start acceptance and last-bit detection.
    always_comb begin
        w_accept = (r_state == IDLE) && bus.start;
        w_last   = (r_state == SHIFT) && (r_cnt == LAST_BIT);
    end

    // Operand B and initial carry as latched; subtraction is a + ~b + 1.
    always_comb begin
`ifdef SERIAL_ADDSUB_EN
        if (bus.sub) begin
            w_b_in = ~bus.b;
            w_c_in = 1'b1;
        end else begin
            w_b_in = bus.b;
            w_c_in = bus.cin;
        end
`else
        w_b_in = bus.b;
        w_c_in = bus.cin;
`endif
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (bus.start) w_state_next = SHIFT;
                else           w_state_next = IDLE;
            end
            SHIFT: begin
                if (w_last) w_state_next = DONE;
                else        w_state_next = SHIFT;
            end
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // State register with busy/done registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_busy  <= (w_state_next == SHIFT);
            r_done  <= (w_state_next == DONE);
        end
    end

    // Operand/result datapath; the cell's outputs are used only while shifting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= {WIDTH{1'b0}};
            r_b      <= {WIDTH{1'b0}};
            r_sum_sh <= {WIDTH{1'b0}};
            r_sum    <= {WIDTH{1'b0}};
            r_cnt    <= {CNT_W{1'b0}};
            r_carry  <= 1'b0;
            r_cout   <= 1'b0;
`ifdef SERIAL_ADDSUB_EN
            r_ovf    <= 1'b0;
`endif
        end else if (w_accept) begin
            r_a      <= bus.a;
            r_b      <= w_b_in;
            r_carry  <= w_c_in;
            r_cnt    <= {CNT_W{1'b0}};
            r_sum_sh <= {WIDTH{1'b0}};
        end else if (r_state == SHIFT) begin
            r_sum_sh <= {bus.fa_s, r_sum_sh[WIDTH-1:1]};
            r_carry  <= bus.fa_co;
            r_a      <= {1'b0, r_a[WIDTH-1:1]};
            r_b      <= {1'b0, r_b[WIDTH-1:1]};
            r_cnt    <= r_cnt + CNT_W'(1);
            // Publish the result only once the MSB has been computed.
            if (w_last) begin
                r_sum  <= {bus.fa_s, r_sum_sh[WIDTH-1:1]};
                r_cout <= bus.fa_co;
`ifdef SERIAL_ADDSUB_EN
                r_ovf  <= r_carry ^ bus.fa_co;
`endif
            end
        end
    end

    assign bus.fa_a = r_a[0];
    assign bus.fa_b = r_b[0];
    assign bus.fa_c = r_carry;
    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.sum  = r_sum;
    assign bus.cout = r_cout;
`ifdef SERIAL_ADDSUB_EN
    assign bus.ovf  = r_ovf;
`endif
endmodule

// File: tb/tb_serial_adder_seq.sv
// Self-checking bench for serial_adder_seq with a behavioural full-adder cell and arithmetic model.
// Subtraction/overflow cases run only when SERIAL_ADDSUB_EN is defined.
module tb_serial_adder_seq;
    localparam int W = 8;

    logic clk;
    logic rst_n;
    int   n_total;
    int   n_bad;
    int   fac_ones;

    serial_adder_seq_if #(.WIDTH(W)) bus ();

    serial_adder_seq #(.WIDTH(W), .CNT_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Ideal 1-bit full-adder cell.
    assign bus.fa_s  = bus.fa_a ^ bus.fa_b ^ bus.fa_c;
    assign bus.fa_co = (bus.fa_a & bus.fa_b) | (bus.fa_a & bus.fa_c) | (bus.fa_b & bus.fa_c);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                           input logic tc, input logic tsub, input logic tstart);
        bus.a     = ta;
        bus.b     = tb_v;
        bus.cin   = tc;
        bus.start = tstart;
`ifdef SERIAL_ADDSUB_EN
        bus.sub   = tsub;
`else
        if (tsub) $display("note: sub requested without SERIAL_ADDSUB_EN");
`endif
    endtask

    // One operation: checks latency, busy length, result and that done is a single pulse.
    task automatic do_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                         input logic tc, input logic tsub);
        int        edges;
        int        busy_cnt;
        logic [W:0] full;
        int        sres;
        full = tsub ? ({1'b0, ta} + 9'd256 - {1'b0, tb_v}) : ({1'b0, ta} + {1'b0, tb_v} + {8'd0, tc});
        sres = tsub ? ($signed(ta) - $signed(tb_v)) : ($signed(ta) + $signed(tb_v) + int'(tc));
        @(negedge clk);
        set_req(ta, tb_v, tc, tsub, 1'b1);
        @(posedge clk);
        edges = 1;
        @(negedge clk);
        bus.start = 1'b0;
        busy_cnt = 0;
        fac_ones = 0;
        while (!bus.done && edges < 40) begin
            if (bus.busy) busy_cnt++;
            if (bus.busy && bus.fa_c) fac_ones++;
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        // Edges counted inclusive of the start edge: N..N+WIDTH.
        check_eq({tag, "_latency"}, edges, 9);
        check_eq({tag, "_busy_cycles"}, busy_cnt, 8);
        check_eq({tag, "_sum"}, bus.sum, full[W-1:0]);
        check_eq({tag, "_cout"}, bus.cout, full[W]);
`ifdef SERIAL_ADDSUB_EN
        check_eq({tag, "_ovf"}, bus.ovf, (sres > 127 || sres < -128) ? 1 : 0);
`else
        if (sres > 1000) $display("note: unexpected signed result");
`endif
        @(posedge clk);
        @(negedge clk);
        check_eq({tag, "_done_pulse"}, bus.done, 0);
        check_eq({tag, "_sum_hold"}, bus.sum, full[W-1:0]);
    endtask

    initial begin
        int prev;
        int nd;
        int edges;
        n_total = 0;
        n_bad   = 0;
        rst_n   = 1'b0;
        set_req(8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_busy", bus.busy, 0);
        check_eq("rst_done", bus.done, 0);
        check_eq("rst_sum", bus.sum, 0);
        check_eq("rst_cout", bus.cout, 0);
        check_eq("rst_fa_c", bus.fa_c, 0);
        rst_n = 1'b1;

        do_op("basic", 8'h3C, 8'h05, 1'b0, 1'b0);
        do_op("ripple", 8'hFF, 8'h00, 1'b1, 1'b0);
        check_eq("ripple_fa_c_ones", fac_ones, 8);
        for (int i = 0; i < 16; i++) begin
            do_op("rand", 8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
        end

        // Second start mid-SHIFT must be discarded.
        @(negedge clk);
        set_req(8'h10, 8'h10, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        set_req(8'h01, 8'h01, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        bus.start = 1'b0;
        edges = 0;
        while (!bus.done && edges < 20) begin
            @(negedge clk);
            edges++;
        end
        check_eq("ignored_done_seen", bus.done, 1);
        check_eq("ignored_sum", bus.sum, 8'h20);
        nd = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (bus.done) nd++;
        end
        check_eq("ignored_extra_done", nd, 0);

        // start held high re-triggers every WIDTH+2 cycles.
        @(negedge clk);
        set_req(8'hAA, 8'h55, 1'b0, 1'b0, 1'b1);
        prev = -1;
        nd = 0;
        for (int i = 0; i < 35; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.done) begin
                nd++;
                check_eq("b2b_sum", bus.sum, 8'hFF);
                check_eq("b2b_cout", bus.cout, 0);
                if (prev >= 0) check_eq("b2b_period", i - prev, 10);
                prev = i;
            end
        end
        check_eq("b2b_count", nd, 3);
        bus.start = 1'b0;
        repeat (12) @(negedge clk);

        // Reset on the 3rd SHIFT cycle aborts with no later done.
        @(negedge clk);
        set_req(8'hFF, 8'h01, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("abort_busy", bus.busy, 0);
        check_eq("abort_done", bus.done, 0);
        check_eq("abort_sum", bus.sum, 0);
        check_eq("abort_cout", bus.cout, 0);
        @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (bus.done || bus.busy) nd++;
        end
        check_eq("abort_no_done", nd, 0);

`ifdef SERIAL_ADDSUB_EN
        do_op("sub_neg", 8'h05, 8'h07, 1'b0, 1'b1);
        do_op("add_ovf", 8'h7F, 8'h01, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            do_op("rand_sub", 8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
        end
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/serial_adder_seq.md
Name: serial_adder_seq

Overview:
- Bit-serial sequencer that feeds the team's 1-bit full-adder cell, sitting directly upstream of it.
- Latches two WIDTH-bit operands and a carry-in, then presents one bit pair plus the running carry to the cell each clock, LSB first.
- Captures the cell's sum and carry-out back into a result shift register.
- Trades area for latency: one external full-adder cell performs a WIDTH-bit add in WIDTH cycles.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.
- CNT_W, 5, bit-counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  operand A; latched on accepted start.
- b  input  WIDTH  operand B; latched on accepted start.
- cin  input  1  carry-in; latched on accepted start.
- fa_a  output  1  current A bit to the full-adder cell.
- fa_b  output  1  current B bit to the full-adder cell.
- fa_c  output  1  current carry to the full-adder cell.
- fa_s  input  1  sum bit returned by the cell (combinational from fa_a/fa_b/fa_c).
- fa_co  input  1  carry-out returned by the cell.
- busy  output  1  high while in SHIFT.
- done  output  1  one-cycle pulse when result is valid.
- sum  output  WIDTH  result; holds until the next accepted start.
- cout  output  1  final carry-out; holds with sum.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; operand regs, sum, cout, busy, done, and carry reg all 0; bit counter 0.
- fa_a = LSB of A shift reg; fa_b = LSB of B shift reg; fa_c = carry reg. All three are registered sources, so the cell is the only combinational path.
- States:
  - IDLE: busy=0. On start=1, latch a, b, carry<=cin, counter<=0, clear sum shift reg, go to SHIFT. Otherwise stay.
  - SHIFT: busy=1. Each cycle:
    - shift fa_s into sum MSB, shifting right;
    - carry<=fa_co;
    - shift A and B right by 1, zero fill;
    - counter++.
    - When counter==WIDTH-1, this is the last bit: go to DONE.
  - DONE: busy=0, done=1 for exactly this cycle. cout holds the final carry. Unconditionally go to IDLE.
- Latency:
  - start sampled at edge N;
  - SHIFT occupies edges N+1..N+WIDTH;
  - done high in the cycle after edge N+WIDTH;
  - sum/cout valid from that cycle onward.
- start while busy or in DONE is ignored, with no queuing. start held high in IDLE re-triggers every WIDTH+2 cycles.
- sum and cout update only at the end of SHIFT. sum is not cleared while idle. The value at its LSB-side during SHIFT is partial and must not be used before done.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1), unsigned.
- Reset mid-SHIFT aborts immediately with all outputs at reset values. No done is issued for the aborted operation.
- fa_s/fa_co are ignored outside SHIFT.

Optional Feature:
- Macro: SERIAL_ADDSUB_EN.
- When defined:
  - adds input port sub (1 bit), sampled with start;
  - if sub=1, B is latched as ~b and carry is latched as 1 (cin ignored), giving sum = a - b;
  - cout=1 means no borrow;
  - adds output ovf (1 bit): signed overflow = carry into MSB XOR carry out of MSB, valid with done, reset 0.
- When undefined: no sub/ovf ports; add-only behaviour as above.

Test Plan:
- Reset mid-op: start with a=8'hFF, b=8'h01; assert rst_n=0 on the 3rd SHIFT cycle -> busy, done, sum, cout all 0 immediately; no done pulse after release.
- Basic add: a=8'h3C, b=8'h05, cin=0, correct cell attached -> done exactly 9 cycles after the start edge; sum=8'h41, cout=0; busy high 8 cycles.
- Carry ripple: a=8'hFF, b=8'h00, cin=1 -> sum=8'h00, cout=1; fa_c observed as 1 on all 8 SHIFT cycles.
- Start ignored: pulse start with a=8'h10, b=8'h10; pulse start again mid-SHIFT with a=8'h01, b=8'h01 -> single done, sum=8'h20; second request discarded.
- Back-to-back: hold start high with a=8'hAA, b=8'h55 -> done every 10 cycles, sum=8'hFF, cout=0 each time.
- SERIAL_ADDSUB_EN cases:
  - sub=1, a=8'h05, b=8'h07 -> sum=8'hFE, cout=0, ovf=0;
  - sub=0, a=8'h7F, b=8'h01 -> sum=8'h80, ovf=1.
